// File: rtl/riscy32_pkg.sv
// riscy32 shared definitions for the execute-stage multiply/divide unit.
// Holds the datapath width, funct3 operation encodings and FSM states.
package riscy32_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Optional MULDIV_EARLY_OUT_EN lets special-case operations skip CALC.
module muldiv_unit #(
    parameter int XLEN = riscy32_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] rd
);
    import riscy32_pkg::*;

    localparam int CW = $clog2(XLEN);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES = '1;
    localparam logic [CW-1:0]   LAST = CW'(XLEN-1);

    muldiv_state_e   state, state_nxt;
    muldiv_op_e      op_in, op_q;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] opnd;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic            sa, sb;
    logic            spec;
    logic [XLEN-1:0] spec_res;

    logic            is_div, sgn_a, sgn_b, na, nb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div0, ovf, mz, spec_in;
    logic [XLEN-1:0] spec_val;
    logic            accept, finish;

    logic [XLEN:0]   sum, sh, diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
    logic [XLEN-1:0] quo, rem, res, fin;

    assign op_in = muldiv_op_e'(op);

    // decode request: operand signs, magnitudes and RV32M special cases
    always_comb begin
        is_div   = op[2];
        sgn_a    = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                   (op_in == OP_DIV)  || (op_in == OP_REM);
        sgn_b    = (op_in == OP_MULH) || (op_in == OP_DIV) ||
                   (op_in == OP_REM);
        na       = sgn_a & rs1[XLEN-1];
        nb       = sgn_b & rs2[XLEN-1];
        mag_a    = na ? -rs1 : rs1;
        mag_b    = nb ? -rs2 : rs2;
        div0     = is_div && (rs2 == '0);
        ovf      = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (rs1 == MINV) && (rs2 == ONES);
        mz       = !is_div && ((rs1 == '0) || (rs2 == '0));
        spec_in  = div0 | ovf | mz;
        spec_val = '0;
        if (div0)
            spec_val = op[1] ? rs1 : ONES;
        else if (ovf)
            spec_val = op[1] ? '0 : MINV;
    end

    // one iteration of the shared datapath plus final sign fix-up
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
        mul_nxt = acc[0] ? {sum, acc[XLEN-1:1]}
                         : {1'b0, acc[2*XLEN-1:1]};
        sh      = acc[2*XLEN-2:XLEN-1];
        diff    = sh - {1'b0, opnd};
        div_nxt = diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_nxt = op_q[2] ? div_nxt : mul_nxt;
        prod    = (sa ^ sb) ? -acc_nxt : acc_nxt;
        quo     = acc_nxt[XLEN-1:0];
        rem     = acc_nxt[2*XLEN-1:XLEN];
        res     = '0;
        unique case (op_q)
            OP_MUL:    res = prod[XLEN-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU:  res = prod[2*XLEN-1:XLEN];
            OP_DIV,
            OP_DIVU:   res = (sa ^ sb) ? -quo : quo;
            OP_REM,
            OP_REMU:   res = sa ? -rem : rem;
        endcase
        fin = spec ? spec_res : res;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        valid     = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && start) begin
                    accept    = 1'b1;
                    state_nxt = (EARLY && spec_in) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                valid     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, iteration and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MUL;
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            spec     <= 1'b0;
            spec_res <= '0;
            rd       <= '0;
        end else if (accept) begin
            op_q     <= op_in;
            cnt      <= '0;
            opnd     <= is_div ? mag_b : mag_a;
            acc      <= {{XLEN{1'b0}}, is_div ? mag_a : mag_b};
            sa       <= na;
            sb       <= nb;
            spec     <= spec_in;
            spec_res <= spec_val;
            if (EARLY && spec_in)
                rd <= spec_val;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (finish)
                rd <= fin;
        end
    end

endmodule
